// File: rtl/adc_spi_pkg.sv
// adc_spi_pkg: shared definitions for the ADC SPI read-out path.
//   - state_e      : read-out FSM states
//   - SYNC_PATTERN : fixed low bits of the status byte (host framing check)
//   - STATUS_W     : status byte width
//   - frame_header : builds the status byte that precedes every sample
package adc_spi_pkg;

  localparam logic [2:0]  SYNC_PATTERN = 3'b101;
  localparam int unsigned STATUS_W     = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_DONE
  } state_e;

  // Status byte: {valid, overflow, occupancy saturated to 3 bits, sync pattern}
  function automatic logic [STATUS_W-1:0] frame_header(input logic        valid,
                                                       input logic        ovf,
                                                       input int unsigned count);
    logic [2:0] c3;
    c3 = (count > 7) ? 3'd7 : count[2:0];
    return {valid, ovf, c3, SYNC_PATTERN};
  endfunction

endpackage

// File: rtl/adc_spi_target_fifo.sv
// sync_fifo: single-clock first-word-fall-through FIFO.
//   clk_i, rst_ni   : clock, async active-low reset (clears pointers/count)
//   push_i, data_i  : write request and data (accepted when not full, or
//                     when full but a pop is accepted in the same cycle)
//   pop_i, data_o   : read request; data_o shows the head entry
//   full_o, empty_o : status flags
//   count_o         : occupancy
module sync_fifo #(
  parameter int unsigned DATA_W     = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          push_i,
  input  logic [DATA_W-1:0]             data_i,
  input  logic                          pop_i,
  output logic [DATA_W-1:0]             data_o,
  output logic                          full_o,
  output logic                          empty_o,
  output logic [$clog2(FIFO_DEPTH):0]   count_o
);
  import adc_spi_pkg::*;

  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CW-1:0]     count_q, count_d;
  logic              push_acc, pop_acc;

  assign full_o   = (count_q == CW'(FIFO_DEPTH));
  assign empty_o  = (count_q == '0);
  assign pop_acc  = pop_i && !empty_o;
  assign push_acc = push_i && (!full_o || pop_acc);
  assign data_o   = mem_q[rptr_q];
  assign count_o  = count_q;

  always_comb begin
    wptr_d  = push_acc ? wptr_q + AW'(1) : wptr_q;
    rptr_d  = pop_acc  ? rptr_q + AW'(1) : rptr_q;
    count_d = count_q;
    case ({push_acc, pop_acc})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_acc) mem_q[wptr_q] <= data_i;
  end

endmodule

// File: rtl/adc_spi_target.sv
// adc_spi_target: SPI target streaming ADC samples to an external host.
//   wb_clk_i, resetb        : system clock, async active-low reset
//   sample_valid/_data      : one-cycle sample strobe and data into the FIFO
//   spi_sck, spi_csb        : host clock / chip select (asynchronous)
//   spi_sdo, spi_sdo_oe     : serial data (MSB first, mode 0) and pad enable
//   fifo_count              : FIFO occupancy
//   overflow                : sticky drop flag, cleared when reported
// One frame of 8 + DATA_W bits is sent per chip-select assertion.
module adc_spi_target #(
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                        wb_clk_i,
  input  logic                        resetb,
  input  logic                        sample_valid,
  input  logic [DATA_W-1:0]           sample_data,
  input  logic                        spi_sck,
  input  logic                        spi_csb,
  output logic                        spi_sdo,
  output logic                        spi_sdo_oe,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        overflow
);
  import adc_spi_pkg::*;

  localparam int unsigned FRAME_W = STATUS_W + DATA_W;
  localparam int unsigned CW      = $clog2(FIFO_DEPTH) + 1;
  localparam int unsigned BW      = $clog2(FRAME_W);

  // ---------------- synchronizers ----------------
  logic [SYNC_STAGES-1:0] sck_sync_q, csb_sync_q;
  logic [SYNC_STAGES:0]   sck_chain, csb_chain;

  assign sck_chain = {sck_sync_q, spi_sck};
  assign csb_chain = {csb_sync_q, spi_csb};

  for (genvar g = 0; g < SYNC_STAGES; g++) begin : g_sync
    always_ff @(posedge wb_clk_i or negedge resetb) begin
      if (!resetb) begin
        sck_sync_q[g] <= 1'b0;
        csb_sync_q[g] <= 1'b1;
      end else begin
        sck_sync_q[g] <= sck_chain[g];
        csb_sync_q[g] <= csb_chain[g];
      end
    end
  end

  logic sck_s, csb_s, sck_prev_q, csb_prev_q;
  logic sck_rise, sck_fall, csb_fall;

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign csb_s    = csb_sync_q[SYNC_STAGES-1];
  assign sck_rise =  sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s &  sck_prev_q;
  assign csb_fall = ~csb_s &  csb_prev_q;

  // ---------------- FIFO ----------------
  logic              pop, fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_data;

  sync_fifo #(.DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i   (wb_clk_i),
    .rst_ni  (resetb),
    .push_i  (sample_valid),
    .data_i  (sample_data),
    .pop_i   (pop),
    .data_o  (fifo_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // ---------------- FSM ----------------
  state_e             state_q, state_d;
  logic [FRAME_W-1:0] shreg_q, shreg_d, frame;
  logic [BW-1:0]      bitcnt_q, bitcnt_d;
  logic               ovf_q, ovf_d, load, drop;
  logic [CW-1:0]      count_after;

  assign count_after = fifo_empty ? '0 : fifo_count - CW'(1);
  assign frame = {frame_header(~fifo_empty, ovf_q, 32'(count_after)),
                  fifo_empty ? '0 : fifo_data};

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    bitcnt_d = bitcnt_q;
    pop      = 1'b0;
    load     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (csb_fall) state_d = ST_LOAD;
      end
      ST_LOAD: begin
        if (csb_s) begin
          state_d = ST_IDLE;
        end else begin
          pop      = ~fifo_empty;
          load     = 1'b1;
          shreg_d  = frame;
          bitcnt_d = '0;
          state_d  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (csb_s) begin
          state_d = ST_IDLE;
        end else if (sck_rise) begin
          if (bitcnt_q == BW'(FRAME_W - 1)) state_d = ST_DONE;
          else                              bitcnt_d = bitcnt_q + BW'(1);
        end else if (sck_fall) begin
          shreg_d = {shreg_q[FRAME_W-2:0], 1'b0};
        end
      end
      ST_DONE: begin
        if (csb_s) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // A drop in the reporting cycle wins over the clear.
  assign drop  = sample_valid & fifo_full & ~pop;
  assign ovf_d = drop ? 1'b1 : (load ? 1'b0 : ovf_q);

  always_ff @(posedge wb_clk_i or negedge resetb) begin
    if (!resetb) begin
      state_q    <= ST_IDLE;
      shreg_q    <= '0;
      bitcnt_q   <= '0;
      ovf_q      <= 1'b0;
      sck_prev_q <= 1'b0;
      csb_prev_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      shreg_q    <= shreg_d;
      bitcnt_q   <= bitcnt_d;
      ovf_q      <= ovf_d;
      sck_prev_q <= sck_s;
      csb_prev_q <= csb_s;
    end
  end

  assign spi_sdo_oe = (state_q == ST_SHIFT) || (state_q == ST_DONE);
  assign spi_sdo    = spi_sdo_oe & shreg_q[FRAME_W-1];
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_adc_spi_target.sv
// Directed bench for adc_spi_target acting as a mode-0 SPI host.
module tb_adc_spi_target;
  import adc_spi_pkg::*;

  logic        clk = 1'b0;
  logic        resetb;
  logic        sample_valid;
  logic [15:0] sample_data;
  logic        spi_sck, spi_csb;
  logic        spi_sdo, spi_sdo_oe, overflow;
  logic [2:0]  fifo_count;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  adc_spi_target #(.DATA_W(16), .FIFO_DEPTH(4), .SYNC_STAGES(2)) dut (
    .wb_clk_i     (clk),
    .resetb       (resetb),
    .sample_valid (sample_valid),
    .sample_data  (sample_data),
    .spi_sck      (spi_sck),
    .spi_csb      (spi_csb),
    .spi_sdo      (spi_sdo),
    .spi_sdo_oe   (spi_sdo_oe),
    .fifo_count   (fifo_count),
    .overflow     (overflow)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [15:0] d);
    @(negedge clk);
    sample_valid = 1'b1;
    sample_data  = d;
    @(negedge clk);
    sample_valid = 1'b0;
  endtask

  // Full 24-bit mode-0 read; optionally pulses sample_valid in the LOAD cycle.
  task automatic spi_read(output logic [23:0] frame, input bit push_in_load,
                          input logic [15:0] pdata);
    frame = '0;
    @(negedge clk);
    spi_csb = 1'b0;
    repeat (3) @(negedge clk);
    if (push_in_load) begin
      check("state_load", 32'(dut.state_q), 32'(ST_LOAD));
      sample_valid = 1'b1;
      sample_data  = pdata;
      @(negedge clk);
      sample_valid = 1'b0;
      repeat (4) @(negedge clk);
    end else begin
      repeat (5) @(negedge clk);
    end
    for (int i = 0; i < 24; i++) begin
      frame[23-i] = spi_sdo;
      spi_sck = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
      repeat (8) @(negedge clk);
    end
    spi_csb = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  logic [23:0] fr;

  initial begin
    resetb       = 1'b0;
    sample_valid = 1'b0;
    sample_data  = '0;
    spi_sck      = 1'b0;
    spi_csb      = 1'b1;

    // Reset with random host activity
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      spi_sck = 1'($urandom_range(1));
      spi_csb = 1'($urandom_range(1));
    end
    check("rst_sdo", 32'(spi_sdo), 32'd0);
    check("rst_oe", 32'(spi_sdo_oe), 32'd0);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_ovf", 32'(overflow), 32'd0);
    @(negedge clk);
    spi_sck = 1'b0;
    spi_csb = 1'b1;
    resetb  = 1'b1;
    repeat (4) @(negedge clk);
    check("rst_state", 32'(dut.state_q), 32'(ST_IDLE));
    check("rst_oe_post", 32'(spi_sdo_oe), 32'd0);

    // Single sample
    push(16'hA5C3);
    check("single_count1", 32'(fifo_count), 32'd1);
    spi_read(fr, 1'b0, '0);
    check("single_frame", 32'(fr), 32'h85A5C3);
    check("single_count0", 32'(fifo_count), 32'd0);
    check("single_oe_off", 32'(spi_sdo_oe), 32'd0);

    // Empty read
    spi_read(fr, 1'b0, '0);
    check("empty_frame", 32'(fr), 32'h050000);
    check("empty_count", 32'(fifo_count), 32'd0);

    // Overflow: five back-to-back pushes into depth 4
    @(negedge clk);
    sample_valid = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      sample_data = 16'(i);
      @(negedge clk);
    end
    sample_valid = 1'b0;
    check("ovf_flag", 32'(overflow), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd4);
    spi_read(fr, 1'b0, '0);
    check("ovf_frame1", 32'(fr), 32'hDD0001);
    check("ovf_cleared", 32'(overflow), 32'd0);
    spi_read(fr, 1'b0, '0);
    check("ovf_frame2", 32'(fr), 32'h950002);
    spi_read(fr, 1'b0, '0);
    check("ovf_frame3", 32'(fr), 32'h8D0003);
    spi_read(fr, 1'b0, '0);
    check("ovf_frame4", 32'(fr), 32'h850004);

    // Abort mid-frame
    push(16'h1234);
    @(negedge clk);
    spi_csb = 1'b0;
    repeat (8) @(negedge clk);
    check("abort_oe_on", 32'(spi_sdo_oe), 32'd1);
    for (int i = 0; i < 10; i++) begin
      spi_sck = 1'b1;
      repeat (8) @(negedge clk);
      spi_sck = 1'b0;
      repeat (8) @(negedge clk);
    end
    spi_csb = 1'b1;
    repeat (8) @(negedge clk);
    check("abort_oe_off", 32'(spi_sdo_oe), 32'd0);
    check("abort_count", 32'(fifo_count), 32'd0);
    check("abort_ovf", 32'(overflow), 32'd0);
    spi_read(fr, 1'b0, '0);
    check("abort_next", 32'(fr), 32'h050000);

    // Simultaneous push/pop while full
    for (int i = 0; i < 4; i++) push(16'h000A + 16'(i));
    check("sim_full", 32'(fifo_count), 32'd4);
    spi_read(fr, 1'b1, 16'h000E);
    check("sim_frameA", 32'(fr), 32'h9D000A);
    check("sim_ovf", 32'(overflow), 32'd0);
    check("sim_count", 32'(fifo_count), 32'd4);
    spi_read(fr, 1'b0, '0);
    check("sim_frameB", 32'(fr), 32'h9D000B);
    spi_read(fr, 1'b0, '0);
    check("sim_frameC", 32'(fr), 32'h95000C);
    spi_read(fr, 1'b0, '0);
    check("sim_frameD", 32'(fr), 32'h8D000D);
    spi_read(fr, 1'b0, '0);
    check("sim_frameE", 32'(fr), 32'h85000E);
    check("sim_empty", 32'(fifo_count), 32'd0);

    // Reset mid-frame discards FIFO contents
    push(16'h5555);
    push(16'h6666);
    @(negedge clk);
    spi_csb = 1'b0;
    repeat (8) @(negedge clk);
    resetb = 1'b0;
    @(negedge clk);
    check("midrst_oe", 32'(spi_sdo_oe), 32'd0);
    check("midrst_count", 32'(fifo_count), 32'd0);
    spi_csb = 1'b1;
    @(negedge clk);
    resetb = 1'b1;
    repeat (4) @(negedge clk);
    spi_read(fr, 1'b0, '0);
    check("midrst_frame", 32'(fr), 32'h050000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adc_spi_target.md
Name: adc_spi_target

Overview:
- SPI responder (target) that streams VCO-ADC samples off-chip through mprj_io pins to an external host.
- It is the read-out end of the ADC sample path. ADC samples are pushed into a small FIFO; the host pulls one framed sample per chip-select assertion.
- Sits in the user project area between the vco_adc_wrapper sample output and the GPIO pads (sck/csb inputs, sdo output).

Parameters:
- DATA_W, 16, sample width in bits; frame length FRAME_W = 8 + DATA_W.
- FIFO_DEPTH, 4, sample FIFO entries; must be a power of 2 and at most 8.
- SYNC_STAGES, 2, flip-flop stages in each sck/csb synchronizer; minimum 2.

Ports:
- wb_clk_i  in  1  system clock.
- resetb  in  1  asynchronous active-low reset.
- sample_valid  in  1  one-cycle strobe, sample_data is valid.
- sample_data  in  DATA_W  ADC sample.
- spi_sck  in  1  host clock, asynchronous to wb_clk_i.
- spi_csb  in  1  host chip select, active low, asynchronous.
- spi_sdo  out  1  serial data, MSB first.
- spi_sdo_oe  out  1  pad output enable.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- overflow  out  1  sticky sample-drop flag.

Behaviour:
- Reset: all outputs 0; FIFO empty; state IDLE; synchronizers cleared with the csb chain reset to 1. Reset asserted mid-frame aborts the frame and discards FIFO contents.
- Synchronization: spi_sck and spi_csb each pass through SYNC_STAGES flip-flops. Edges are detected on the synchronized versions. Host must keep sck at or below wb_clk_i/8 and leave at least 4 clk cycles between csb fall and the first sck rise.
- Push: sample_valid with FIFO not full writes the sample and increments the count. If the FIFO is full and no pop occurs in the same cycle, the sample is dropped and overflow is set.
- Simultaneous push and pop while full: push is accepted and the count is unchanged.
- Frame format: bits [FRAME_W-1:DATA_W] = status byte {valid, overflow, count3[2:0], 3'b101}; bits [DATA_W-1:0] = sample, or 0 when the FIFO is empty.
  - count3 is the occupancy after the pop, saturated at 7.
  - The overflow bit reports the flag value at LOAD. The flag clears in that same LOAD cycle unless a new drop occurs in that cycle; a drop wins.
- FSM:
  - IDLE: sdo_oe=0, sdo=0. Synchronized csb falling edge -> LOAD.
  - LOAD (1 cycle): pop if non-empty, build frame into the shift register, sdo = frame MSB, sdo_oe=1, bit counter = 0 -> SHIFT.
  - SHIFT: each synchronized sck rising edge increments the bit counter. Each synchronized sck falling edge shifts left and drives the next bit on sdo. After FRAME_W rising edges -> DONE.
  - DONE: sdo held at the last bit, sdo_oe=1. csb high -> IDLE.
- Early csb rise in SHIFT or LOAD: go directly to IDLE, sdo_oe=0. A popped sample is lost and does not set overflow.
- Extra sck edges in DONE or IDLE are ignored.
- Latency: sdo carries the frame MSB SYNC_STAGES+2 clk cycles after the spi_csb fall.

Decomposition:
- Shared package adc_spi_pkg holds:
  - FSM state encoding (IDLE, LOAD, SHIFT, DONE)
  - SYNC_PATTERN = 3'b101
  - STATUS_W = 8
  - the frame-assembly function
- One natural sub-module: sync_fifo (parameterised DATA_W/FIFO_DEPTH, push/pop/full/empty/count, async active-low reset), reusable by the other ADC channels.
- The 2-FF synchronizer is inlined as a generate loop.

Test Plan:
- Reset: hold resetb low with random sck/csb toggling -> spi_sdo=0, spi_sdo_oe=0, fifo_count=0, overflow=0; after release, state IDLE.
- Single sample: push 0xA5C3, then a 24-bit mode-0 read -> host captures 0x85A5C3; fifo_count returns to 0; sdo_oe high only while csb is low (plus sync latency).
- Empty read: read with an empty FIFO -> 0x050000; fifo_count stays 0.
- Overflow: push 0x0001..0x0005 back-to-back (depth 4) -> overflow=1, fifo_count=4. First read gives 0xDD0001; overflow clears; second read gives 0x950002.
- Abort: push 0x1234, raise csb after 10 sck cycles -> sdo_oe drops, FIFO empty, overflow=0. Next read gives 0x050000.
- Simultaneous push/pop: FIFO full, a sample_valid pulse lands in the LOAD cycle -> no drop, overflow stays 0, fifo_count stays 4. Four consecutive reads return the samples in push order.
